// File: rtl/demux4_buf.sv
// demux4_buf: 1-to-4 valid/ready demultiplexer. Each source beat is steered by
// its lane select into one of four independent FIFOs, and each FIFO drives its
// own valid/ready consumer. Source-side ready depends only on registered
// occupancy, so no consumer ready ever reaches in_ready combinationally.
module demux4_buf #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_sel,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [3:0]            out_valid,
   input  logic [3:0]            out_ready,
   output logic [DATA_WIDTH-1:0] out_data0,
   output logic [DATA_WIDTH-1:0] out_data1,
   output logic [DATA_WIDTH-1:0] out_data2,
   output logic [DATA_WIDTH-1:0] out_data3,
   output logic [3:0]            lane_full,
   output logic                  busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   // Pointers wrap for free only when DEPTH is a power of two.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("demux4_buf: DEPTH must be a power of 2 and at least 2");
   end

   logic [DATA_WIDTH-1:0] mem_q    [4][DEPTH];
   ptr_t                  wr_ptr_q [4];
   ptr_t                  wr_ptr_d [4];
   ptr_t                  rd_ptr_q [4];
   ptr_t                  rd_ptr_d [4];
   cnt_t                  count_q  [4];
   cnt_t                  count_d  [4];
   logic [3:0]            push;
   logic [3:0]            pop;

   // Per-lane status decoded from registered occupancy.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         out_valid[k] = (count_q[k] != '0);
         lane_full[k] = (count_q[k] == FULL_CNT);
      end
   end

   assign busy     = |out_valid;
   // Refusal of a full lane uses pre-pop state, even if that lane pops now.
   assign in_ready = !rst && !lane_full[in_sel];

   // Head entry of each lane; held stable until that lane pops.
   assign out_data0 = mem_q[0][rd_ptr_q[0]];
   assign out_data1 = mem_q[1][rd_ptr_q[1]];
   assign out_data2 = mem_q[2][rd_ptr_q[2]];
   assign out_data3 = mem_q[3][rd_ptr_q[3]];

   // Next-state pointers and counts for every lane from push/pop handshakes.
   always_comb begin
      // NOTE: every variable here is assigned on every pass before any use,
      // with blocking assignments, so no latch can be inferred.
      for (int k = 0; k < 4; k++) begin
         push[k]     = in_valid && in_ready && (in_sel == 2'(k));
         pop[k]      = out_valid[k] && out_ready[k];
         wr_ptr_d[k] = push[k] ? wr_ptr_q[k] + ptr_t'(1) : wr_ptr_q[k];
         rd_ptr_d[k] = pop[k]  ? rd_ptr_q[k] + ptr_t'(1) : rd_ptr_q[k];
         count_d[k]  = count_q[k] + cnt_t'(push[k]) - cnt_t'(pop[k]);
      end
   end

   // Register update: reset empties all lanes and clears storage, otherwise
   // commit the handshakes and write the accepted beat into its lane.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            count_q[k]  <= '0;
            // NOTE: storage is cleared too, since the head outputs of every
            // lane must read zero straight after reset.
            for (int d = 0; d < DEPTH; d++) begin
               mem_q[k][d] <= '0;
            end
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            wr_ptr_q[k] <= wr_ptr_d[k];
            rd_ptr_q[k] <= rd_ptr_d[k];
            count_q[k]  <= count_d[k];
            if (push[k]) begin
               mem_q[k][wr_ptr_q[k]] <= in_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_demux4_buf.sv
// tb_demux4_buf: directed scenarios plus random traffic for demux4_buf, checked
// by a per-lane queue scoreboard filled on acceptance and drained by a monitor.
module tb_demux4_buf;

   localparam int DW    = 32;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_sel;
   logic [DW-1:0] in_data;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
   logic [3:0]    lane_full;
   logic          busy;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q [4][$];   // expected head order per lane
   int            occ   [4];      // reference occupancy per lane
   bit            last_accept = 1'b0;
   bit            mon_en      = 1'b0;
   bit            toggle3     = 1'b0;

   always #5 clk = ~clk;

   demux4_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_data3 (out_data3),
      .lane_full (lane_full),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] head(input int k);
      case (k)
         0:       return out_data0;
         1:       return out_data1;
         2:       return out_data2;
         default: return out_data3;
      endcase
   endfunction

   // Predictor: at each edge decide acceptance from reference occupancy
   // (before this edge's pops) and enqueue the expected beat.
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            occ[k] = 0;
            exp_q[k].delete();
         end
         last_accept = 1'b0;
      end else begin
         last_accept = in_valid && (occ[in_sel] < DEPTH);
         for (int k = 0; k < 4; k++) begin
            if (out_ready[k] && occ[k] > 0) occ[k]--;
         end
         if (last_accept) begin
            occ[in_sel]++;
            exp_q[in_sel].push_back(in_data);
         end
      end
   end

   // Monitor: mid-cycle, compare status and head data, then retire popped heads.
   always @(negedge clk) begin
      if (mon_en) begin
         int total;
         total = 0;
         for (int k = 0; k < 4; k++) total += exp_q[k].size();
         check("in_ready", in_ready, !rst && (exp_q[in_sel].size() < DEPTH));
         check("busy", busy, total != 0);
         for (int k = 0; k < 4; k++) begin
            check($sformatf("out_valid[%0d]", k), out_valid[k], exp_q[k].size() != 0);
            check($sformatf("lane_full[%0d]", k), lane_full[k], exp_q[k].size() == DEPTH);
            if (exp_q[k].size() != 0) begin
               if (out_valid[k]) check($sformatf("out_data%0d", k), head(k), exp_q[k][0]);
               if (out_ready[k]) void'(exp_q[k].pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle3) out_ready[3] = ~out_ready[3];
   endtask

   // Present one beat and hold it until the reference says it was taken.
   task automatic send(input logic [1:0] sel, input logic [DW-1:0] data);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = data;
      do begin
         tick();
         waited++;
      end while (!last_accept && waited < 50);
      if (!last_accept) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: lane %0d data %0h not accepted in 50 cycles", sel, data);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = '0;
      out_ready = 4'h0;
      tick();
      mon_en = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 4'h0);
      check("rst_lane_full", lane_full, 4'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_data", {out_data0, out_data1}, 64'h0);

      // 1: route one beat to each lane on consecutive cycles.
      out_ready = 4'hF;
      send(2'd0, 32'hAAAA0000);
      send(2'd1, 32'hBBBB0001);
      send(2'd2, 32'hCCCC0002);
      send(2'd3, 32'hDDDD0003);
      tick();
      tick();
      check("t1_busy_idle", busy, 1'b0);

      // 2: fill lane 2 under backpressure, other lanes keep flowing.
      out_ready = 4'b1011;
      send(2'd2, 32'h11);
      send(2'd2, 32'h22);
      send(2'd0, 32'h5A);
      in_valid = 1'b1;
      in_sel   = 2'd2;
      in_data  = 32'h33;
      #1;
      check("t2_lane_full", lane_full[2], 1'b1);
      check("t2_refused", in_ready, 1'b0);
      out_ready[2] = 1'b1;
      tick();
      check("t2_ready_after_pop", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();

      // 3: full lane pops while a push is presented; push must wait a cycle.
      out_ready = 4'b1101;
      send(2'd1, 32'h11);
      send(2'd1, 32'h22);
      in_valid     = 1'b1;
      in_sel       = 2'd1;
      in_data      = 32'h44;
      out_ready[1] = 1'b1;
      #1;
      check("t3_refused_on_pop", in_ready, 1'b0);
      tick();
      check("t3_ready_next", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      repeat (3) tick();

      // 4: stream through lane 3 with a toggling consumer to wrap pointers.
      out_ready = 4'b1000;
      toggle3   = 1'b1;
      for (int i = 0; i < 10; i++) send(2'd3, DW'(i));
      toggle3   = 1'b0;
      out_ready = 4'hF;
      repeat (4) tick();
      check("t4_drained", busy, 1'b0);

      // 5: reset with buffered data and a beat on the input.
      out_ready = 4'h0;
      send(2'd0, 32'h01);
      send(2'd0, 32'h02);
      send(2'd3, 32'h03);
      send(2'd3, 32'h04);
      check("t5_preload_full", lane_full, 4'b1001);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_sel   = 2'd0;
      in_data  = 32'h55;
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check("t5_valid", out_valid, 4'h0);
      check("t5_full", lane_full, 4'h0);
      check("t5_data01", {out_data0, out_data1}, 64'h0);
      check("t5_data23", {out_data2, out_data3}, 64'h0);
      tick();
      check("t5_beat_dropped", out_valid, 4'h0);

      // 6: one beat per lane, then all four lanes pop together.
      for (int k = 0; k < 4; k++) send(2'(k), $urandom);
      check("t6_all_valid", out_valid, 4'hF);
      out_ready = 4'hF;
      tick();
      check("t6_all_popped", out_valid, 4'h0);
      check("t6_busy", busy, 1'b0);

      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 63) == 0);
         in_valid  = $urandom_range(0, 1) != 0;
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = $urandom;
         out_ready = 4'($urandom);
         tick();
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 4'hF;
      repeat (4) tick();
      check("final_idle", busy, 1'b0);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
